// File: rtl/ecr_allocator.sv
// ECR allocator: round-robin grant of condition registers, per-entry FREE/PENDING/RESOLVED tracking.
// Optional statistics counters are built only when ECR_ALLOC_STATS_EN is defined.
module ecr_allocator #(
    parameter  int NUM_ECRS  = 2,
    parameter  int CNT_WIDTH = 32,
    localparam int IW        = $clog2(NUM_ECRS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_req,
    output logic                  alloc_gnt,
    output logic [IW-1:0]         alloc_id,
    output logic                  issue_wen,
    output logic [IW-1:0]         issue_write_addr,
    output logic [1:0]            issue_wdata,
    input  logic [2*NUM_ECRS-1:0] ecr_states,
    input  logic                  release_valid,
    input  logic [IW-1:0]         release_id,
    output logic                  cur_valid,
    output logic [IW-1:0]         cur_id,
    output logic                  resolve_valid,
    output logic [IW-1:0]         resolve_id,
    output logic                  resolve_ok,
    output logic [IW:0]           free_count,
    output logic                  err_bad_release,
    output logic [CNT_WIDTH-1:0]  stat_alloc,
    output logic [CNT_WIDTH-1:0]  stat_ok,
    output logic [CNT_WIDTH-1:0]  stat_bad
);

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_RESOLVED = 2'd2
    } ecr_st_e;

    ecr_st_e       state_q [NUM_ECRS];
    ecr_st_e       state_d [NUM_ECRS];
    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] cur_id_q, cur_id_d;
    logic          cur_valid_q, cur_valid_d;
    logic          res_valid_q, res_valid_d;
    logic [IW-1:0] res_id_q, res_id_d;
    logic          res_ok_q, res_ok_d;
    logic          err_q, err_d;

    logic          any_free;
    logic [IW-1:0] pick_id;
    logic [IW:0]   free_cnt;
    logic          res_hit;
    logic [IW-1:0] res_idx;
    logic [1:0]    res_val;
    logic          rel_ok;
    logic          rel_bad;

    // Round-robin search for the first FREE entry starting at rr_q.
    always_comb begin
        any_free = 1'b0;
        pick_id  = '0;
        free_cnt = '0;
        for (int i = 0; i < NUM_ECRS; i++) begin
            if (!any_free && state_q[IW'(rr_q + IW'(i))] == ST_FREE) begin
                any_free = 1'b1;
                pick_id  = IW'(rr_q + IW'(i));
            end
            if (state_q[i] == ST_FREE) begin
                free_cnt = free_cnt + (IW+1)'(1);
            end
        end
    end

    // Only the lowest-indexed PENDING entry with a non-busy value resolves per edge.
    always_comb begin
        res_hit = 1'b0;
        res_idx = '0;
        res_val = 2'b00;
        for (int k = 0; k < NUM_ECRS; k++) begin
            if (!res_hit && state_q[k] == ST_PENDING && ecr_states[2*k +: 2] != 2'b00) begin
                res_hit = 1'b1;
                res_idx = IW'(k);
                res_val = ecr_states[2*k +: 2];
            end
        end
    end

    assign rel_ok  = release_valid && (state_q[release_id] == ST_RESOLVED);
    assign rel_bad = release_valid && !rel_ok;

    assign alloc_gnt        = alloc_req && any_free;
    assign alloc_id         = pick_id;
    assign issue_wen        = alloc_gnt;
    assign issue_write_addr = pick_id;
    assign issue_wdata      = 2'b00;
    assign free_count       = free_cnt;

    // Grant, resolve and release always hit different entries since each needs a distinct state.
    always_comb begin
        for (int k = 0; k < NUM_ECRS; k++) begin
            state_d[k] = state_q[k];
        end
        rr_d        = rr_q;
        cur_id_d    = cur_id_q;
        cur_valid_d = cur_valid_q;
        res_valid_d = res_hit;
        res_id_d    = res_hit ? res_idx : res_id_q;
        res_ok_d    = res_hit ? (res_val == 2'b01) : res_ok_q;
        err_d       = err_q | rel_bad | (res_hit && res_val == 2'b11);

        if (alloc_gnt) begin
            state_d[pick_id] = ST_PENDING;
            rr_d             = IW'(pick_id + IW'(1));
            cur_id_d         = pick_id;
            cur_valid_d      = 1'b1;
        end else if (rel_ok && release_id == cur_id_q) begin
            cur_valid_d = 1'b0;
        end

        if (res_hit) begin
            state_d[res_idx] = ST_RESOLVED;
        end
        if (rel_ok) begin
            state_d[release_id] = ST_FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_ECRS; k++) begin
                state_q[k] <= ST_FREE;
            end
            rr_q        <= '0;
            cur_id_q    <= '0;
            cur_valid_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_ok_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_ECRS; k++) begin
                state_q[k] <= state_d[k];
            end
            rr_q        <= rr_d;
            cur_id_q    <= cur_id_d;
            cur_valid_q <= cur_valid_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_ok_q    <= res_ok_d;
            err_q       <= err_d;
        end
    end

    assign cur_valid       = cur_valid_q;
    assign cur_id          = cur_id_q;
    assign resolve_valid   = res_valid_q;
    assign resolve_id      = res_id_q;
    assign resolve_ok      = res_ok_q;
    assign err_bad_release = err_q;

`ifdef ECR_ALLOC_STATS_EN
    logic [CNT_WIDTH-1:0] st_alloc_q, st_ok_q, st_bad_q;

    // Counters advance on the same edge that registers the grant or resolve event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_alloc_q <= '0;
            st_ok_q    <= '0;
            st_bad_q   <= '0;
        end else begin
            if (alloc_gnt) begin
                st_alloc_q <= st_alloc_q + CNT_WIDTH'(1);
            end
            if (res_hit && res_val == 2'b01) begin
                st_ok_q <= st_ok_q + CNT_WIDTH'(1);
            end
            if (res_hit && res_val != 2'b01) begin
                st_bad_q <= st_bad_q + CNT_WIDTH'(1);
            end
        end
    end

    assign stat_alloc = st_alloc_q;
    assign stat_ok    = st_ok_q;
    assign stat_bad   = st_bad_q;
`else
    assign stat_alloc = '0;
    assign stat_ok    = '0;
    assign stat_bad   = '0;
`endif

endmodule

// File: tb/tb_ecr_allocator.sv
// Bench for ecr_allocator: directed vector table, then random traffic against a behavioural model.
module tb_ecr_allocator;

    localparam int N  = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alloc_req = 1'b0;
    logic          alloc_gnt;
    logic [0:0]    alloc_id;
    logic          issue_wen;
    logic [0:0]    issue_write_addr;
    logic [1:0]    issue_wdata;
    logic [3:0]    ecr_states = '0;
    logic          release_valid = 1'b0;
    logic [0:0]    release_id = '0;
    logic          cur_valid;
    logic [0:0]    cur_id;
    logic          resolve_valid;
    logic [0:0]    resolve_id;
    logic          resolve_ok;
    logic [1:0]    free_count;
    logic          err_bad_release;
    logic [CW-1:0] stat_alloc, stat_ok, stat_bad;

    ecr_allocator #(.NUM_ECRS(N), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
        .alloc_id(alloc_id), .issue_wen(issue_wen), .issue_write_addr(issue_write_addr),
        .issue_wdata(issue_wdata), .ecr_states(ecr_states), .release_valid(release_valid),
        .release_id(release_id), .cur_valid(cur_valid), .cur_id(cur_id),
        .resolve_valid(resolve_valid), .resolve_id(resolve_id), .resolve_ok(resolve_ok),
        .free_count(free_count), .err_bad_release(err_bad_release),
        .stat_alloc(stat_alloc), .stat_ok(stat_ok), .stat_bad(stat_bad)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: 0 = free, 1 = pending, 2 = resolved.
    int m_st[N];
    int m_rr, m_cur, m_rid, m_sa, m_so, m_sb;
    bit m_curv, m_rv, m_rok, m_err, m_ok;

    function automatic int m_pick();
        for (int off = 0; off < N; off++)
            if (m_st[(m_rr + off) % N] == 0) return (m_rr + off) % N;
        return -1;
    endfunction

    function automatic int m_free();
        int c = 0;
        foreach (m_st[k]) if (m_st[k] == 0) c++;
        return c;
    endfunction

    task automatic model_check();
        int  p = m_pick();
        bit  g = alloc_req && (p >= 0);
        chk("m_gnt", alloc_gnt, g);
        chk("m_wen", issue_wen, g);
        chk("m_wdata", issue_wdata, 0);
        if (g) begin
            chk("m_id", alloc_id, p);
            chk("m_waddr", issue_write_addr, p);
        end
        chk("m_free", free_count, m_free());
        chk("m_rv", resolve_valid, m_rv);
        if (m_rv) begin
            chk("m_rid", resolve_id, m_rid);
            chk("m_rok", resolve_ok, m_rok);
        end
        chk("m_err", err_bad_release, m_err);
        chk("m_curv", cur_valid, m_curv);
        if (m_curv) chk("m_cur", cur_id, m_cur);
        chk("m_sa", stat_alloc, m_sa);
        chk("m_so", stat_ok, m_so);
        chk("m_sb", stat_bad, m_sb);
    endtask

    task automatic model_edge();
        int p, rk, rv_f;
        bit g, rel_ok;
        if (!rst_n) begin
            foreach (m_st[k]) m_st[k] = 0;
            m_rr = 0; m_cur = 0; m_curv = 0; m_rv = 0; m_rid = 0; m_rok = 0;
            m_err = 0; m_sa = 0; m_so = 0; m_sb = 0; m_ok = 1;
            return;
        end
        p      = m_pick();
        g      = alloc_req && (p >= 0);
        rel_ok = release_valid && m_st[release_id] == 2;
        if (release_valid && !rel_ok) m_err = 1;
        rk = -1; rv_f = 0;
        for (int k = 0; k < N; k++)
            if (rk < 0 && m_st[k] == 1 && ecr_states[2*k +: 2] != 2'b00) begin
                rk = k; rv_f = ecr_states[2*k +: 2];
            end
        m_rv = (rk >= 0);
        if (m_rv) begin
            m_rid = rk; m_rok = (rv_f == 1);
            if (rv_f == 3) m_err = 1;
            m_st[rk] = 2;
`ifdef ECR_ALLOC_STATS_EN
            if (m_rok) m_so = (m_so + 1) % (1 << CW); else m_sb = (m_sb + 1) % (1 << CW);
`endif
        end
        if (g) begin
            m_st[p] = 1; m_rr = (p + 1) % N; m_cur = p; m_curv = 1;
`ifdef ECR_ALLOC_STATS_EN
            m_sa = (m_sa + 1) % (1 << CW);
`endif
        end else if (rel_ok && release_id == m_cur) begin
            m_curv = 0;
        end
        if (rel_ok) m_st[release_id] = 0;
    endtask

    typedef struct {
        bit       rst, req, rv, rid, chk;
        bit [3:0] st;
        bit       e_gnt, e_id;
        int       e_free;
        bit       e_rv, e_rid, e_rok, e_err, e_curv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit req, bit rv, bit rid, bit [3:0] st, bit c,
                                bit g, bit id, int fr, bit rvo, bit rido, bit rok, bit err, bit cv);
        vec_t v;
        v.rst = rst; v.req = req; v.rv = rv; v.rid = rid; v.st = st; v.chk = c;
        v.e_gnt = g; v.e_id = id; v.e_free = fr; v.e_rv = rvo; v.e_rid = rido;
        v.e_rok = rok; v.e_err = err; v.e_curv = cv;
        return v;
    endfunction

    task automatic apply(input bit r, input bit q, input bit v, input bit id, input logic [3:0] s);
        rst_n = r; alloc_req = q; release_valid = v; release_id = id; ecr_states = s;
        #2;
        if (m_ok) model_check();
    endtask

    initial begin
        m_ok = 0;
        //            rst req rv rid st     chk gnt id free rv rid ok err curv
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 4'b0000, 1, 1, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 4'b0000, 1, 1, 1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 4'b0010, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 4'b1000, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 4'b0000, 1, 0, 0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 4'b0000, 1, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 4'b0000, 1, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 4'b0000, 1, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 4'b0000, 1, 1, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 4'b0101, 1, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 4'b0101, 1, 0, 0, 0, 1, 0, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 1, 1, 1, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1, 1, 4'b0000, 1, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 4'b0000, 1, 1, 1, 2, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 4'b0000, 1, 1, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0101, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 4'b0000, 1, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 4'b0101, 1, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 4'b0000, 1, 1, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 4'b0011, 1, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 4'b0000, 1, 0, 0, 1, 1, 0, 0, 1, 1));

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].req, tbl[i].rv, tbl[i].rid, tbl[i].st);
            if (tbl[i].chk) begin
                chk($sformatf("t%0d_gnt", i), alloc_gnt, tbl[i].e_gnt);
                chk($sformatf("t%0d_wen", i), issue_wen, tbl[i].e_gnt);
                if (tbl[i].e_gnt) begin
                    chk($sformatf("t%0d_id", i), alloc_id, tbl[i].e_id);
                    chk($sformatf("t%0d_waddr", i), issue_write_addr, tbl[i].e_id);
                end
                chk($sformatf("t%0d_free", i), free_count, tbl[i].e_free);
                chk($sformatf("t%0d_rv", i), resolve_valid, tbl[i].e_rv);
                if (tbl[i].e_rv) begin
                    chk($sformatf("t%0d_rid", i), resolve_id, tbl[i].e_rid);
                    chk($sformatf("t%0d_rok", i), resolve_ok, tbl[i].e_rok);
                end
                chk($sformatf("t%0d_err", i), err_bad_release, tbl[i].e_err);
                chk($sformatf("t%0d_curv", i), cur_valid, tbl[i].e_curv);
            end
            model_edge();
            @(posedge clk); #1;
        end

        for (int c = 0; c < 600; c++) begin
            logic [3:0] s;
            for (int k = 0; k < N; k++)
                s[2*k +: 2] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            apply(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), s);
            model_edge();
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ecr_allocator.md
ECR_ALLOCATOR -- requirements
Module: ecr_allocator

Interface
REQ-001 The block SHALL have parameter NUM_ECRS, default 2, meaning number of ECRs managed (power of two, >=2); IW = $clog2(NUM_ECRS).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 32, meaning width of statistics counters.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 alloc_req  input  1  issue stage requests an ECR for a branch.
REQ-006 alloc_gnt  output  1  request granted this cycle.
REQ-007 alloc_id  output  IW  granted ECR index; valid when alloc_gnt=1.
REQ-008 issue_wen, issue_write_addr, issue_wdata  output  1/IW/2  busy-marking write port to the ECR register file.
REQ-009 ecr_states  input  2 x NUM_ECRS  per-ECR value from the register file monitor port (00 busy, 01 correct, 10 incorrect).
REQ-010 release_valid, release_id  input  1/IW  consumer retires ECR release_id.
REQ-011 cur_valid, cur_id  output  1/IW  most recently granted ECR still live, for dependency tagging.
REQ-012 resolve_valid, resolve_id, resolve_ok  output  1/IW/1  one-cycle resolution event.
REQ-013 free_count  output  IW+1  number of FREE entries.
REQ-014 err_bad_release  output  1  sticky protocol-error flag.
REQ-015 stat_alloc, stat_ok, stat_bad  output  CNT_WIDTH each  statistics counters.

Function
REQ-016 Each ECR SHALL have a private FSM with states FREE, PENDING, RESOLVED.
REQ-017 alloc_gnt SHALL be combinational: alloc_req=1 and at least one entry FREE in the current state.
REQ-018 alloc_id SHALL be the first FREE index found searching upward from rr_ptr, with modulo-NUM_ECRS wrap.
REQ-019 On grant, rr_ptr SHALL load (alloc_id+1) mod NUM_ECRS at the edge; without a grant it SHALL hold.
REQ-020 issue_wen SHALL equal alloc_gnt, with issue_write_addr=alloc_id and issue_wdata=2'b00, in the same cycle.
REQ-021 FREE->PENDING SHALL occur at the grant edge.
REQ-022 PENDING->RESOLVED SHALL occur at the first edge where ecr_states[k]!=00.
REQ-023 The PENDING->RESOLVED edge SHALL register resolve_valid=1, resolve_id=k and resolve_ok=(state==01) for exactly one cycle.
REQ-024 If several entries resolve at the same edge, the lowest index SHALL resolve and the others SHALL remain PENDING until later edges.
REQ-025 A state value of 11 SHALL be treated as incorrect (resolve_ok=0) and SHALL set err_bad_release.
REQ-026 RESOLVED->FREE SHALL occur at an edge with release_valid=1 and release_id==k.
REQ-027 A release targeting a FREE or PENDING entry SHALL be ignored and SHALL set err_bad_release.
REQ-028 When an alloc and a release of the same index occur in one cycle, the entry SHALL NOT be granted that cycle; it becomes FREE at the edge and is grantable the next cycle.
REQ-029 With zero FREE entries, alloc_gnt=0 and issue_wen=0; a held request SHALL be granted in the first cycle an entry is FREE.
REQ-030 On grant, cur_id<=alloc_id and cur_valid<=1; a release of cur_id SHALL clear cur_valid unless a grant occurs in the same cycle.
REQ-031 free_count SHALL be combinational from the current FSM states.

Reset
REQ-032 While rst_n=0 at an edge, the block SHALL set all FSMs to FREE, rr_ptr=0, cur_valid=0, cur_id=0, resolve_valid=0, resolve_id=0, resolve_ok=0, err_bad_release=0, and all counters to 0.
REQ-033 After that reset edge, free_count=NUM_ECRS; alloc_gnt and issue_wen SHALL follow REQ-017/REQ-020.
REQ-034 Reset mid-operation SHALL abandon all PENDING/RESOLVED entries with no resolve event emitted.

Configuration
REQ-035 With macro ECR_ALLOC_STATS_EN defined, stat_alloc SHALL increment per grant, stat_ok per resolve_ok=1 event and stat_bad per resolve_ok=0 event.
REQ-036 All three counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-037 Without ECR_ALLOC_STATS_EN, the counters SHALL NOT be instantiated and stat_* outputs SHALL be constant 0.

Verification
REQ-038 Reset, then alloc_req=1 for 3 cycles with no release -> grants id 0, id 1, then alloc_gnt=0; issue_wen pulses with addr 0 then 1 and wdata 00; free_count 2->1->0.
REQ-039 ECR0 PENDING, drive ecr_states[0]=10 -> next cycle resolve_valid=1, resolve_id=0, resolve_ok=0; stat_bad=1 with ECR_ALLOC_STATS_EN, otherwise 0.
REQ-040 Both entries RESOLVED, release_id=1 with alloc_req=1 in the same cycle -> no grant that cycle; next cycle alloc_gnt=1 with alloc_id=1.
REQ-041 release_valid=1, release_id=0 while ECR0 is FREE -> err_bad_release=1 and stays 1 until reset; state unchanged.
REQ-042 ECR0 and ECR1 PENDING, both states go to 01 in the same cycle -> resolve event id 0, then id 1 on the next cycle.
REQ-043 rst_n=0 for one edge while both entries are PENDING -> free_count=2, cur_valid=0, no resolve_valid pulse.
